// File: rtl/sc_ir_fetch_pkg.sv
// Shared types and constants for the IR fetch controller.
package sc_ir_fetch_pkg;

  localparam int unsigned DATAWIDTH_DEFAULT = 32;
  localparam int unsigned ADDRWIDTH_DEFAULT = 32;
  localparam int unsigned TIMEOUT_DEFAULT   = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    LOAD = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/sc_ir_fetch_if.sv
// Fetch controller bus: control-unit request, memory read port and IR load outputs.
interface sc_ir_fetch_if #(
  parameter int unsigned DATAWIDTH_BUS = 32,
  parameter int unsigned ADDRWIDTH_BUS = 32
);
  logic                     SC_IrFetch_Start_InHigh;
  logic [ADDRWIDTH_BUS-1:0] SC_IrFetch_PC_In;
  logic [ADDRWIDTH_BUS-1:0] SC_IrFetch_MemAddr_Out;
  logic                     SC_IrFetch_MemRead_OutHigh;
  logic                     SC_IrFetch_MemReady_InHigh;
  logic [DATAWIDTH_BUS-1:0] SC_IrFetch_MemData_In;
  logic [DATAWIDTH_BUS-1:0] SC_IrFetch_DataBUS_Out;
  logic                     SC_IrFetch_IRWrite_OutHigh;
  logic                     SC_IrFetch_Busy_OutHigh;
  logic                     SC_IrFetch_Done_OutHigh;
  logic                     SC_IrFetch_Error_OutHigh;
  logic [1:0]               SC_IrFetch_ErrCode_Out;

  modport master (
    input  SC_IrFetch_Start_InHigh, SC_IrFetch_PC_In,
    input  SC_IrFetch_MemReady_InHigh, SC_IrFetch_MemData_In,
    output SC_IrFetch_MemAddr_Out, SC_IrFetch_MemRead_OutHigh,
    output SC_IrFetch_DataBUS_Out, SC_IrFetch_IRWrite_OutHigh,
    output SC_IrFetch_Busy_OutHigh, SC_IrFetch_Done_OutHigh,
    output SC_IrFetch_Error_OutHigh, SC_IrFetch_ErrCode_Out
  );

  modport slave (
    output SC_IrFetch_Start_InHigh, SC_IrFetch_PC_In,
    output SC_IrFetch_MemReady_InHigh, SC_IrFetch_MemData_In,
    input  SC_IrFetch_MemAddr_Out, SC_IrFetch_MemRead_OutHigh,
    input  SC_IrFetch_DataBUS_Out, SC_IrFetch_IRWrite_OutHigh,
    input  SC_IrFetch_Busy_OutHigh, SC_IrFetch_Done_OutHigh,
    input  SC_IrFetch_Error_OutHigh, SC_IrFetch_ErrCode_Out
  );
endinterface

// File: rtl/sc_ir_fetch_timer.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
module sc_ir_fetch_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expired
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);
endmodule

// File: rtl/sc_ir_fetch.sv
// Instruction fetch controller: reads one word at PC and loads it into the IR for one cycle.
// Optional memory-ready timeout is built when SC_IRFETCH_TIMEOUT_EN is defined.
module sc_ir_fetch
  import sc_ir_fetch_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS  = DATAWIDTH_DEFAULT,
  parameter int unsigned ADDRWIDTH_BUS  = ADDRWIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic           SC_IrFetch_CLOCK_50,
  input logic           SC_IrFetch_Reset_InLow,
  sc_ir_fetch_if.master bus
);
  state_e                   r_state, w_state_d;
  logic [ADDRWIDTH_BUS-1:0] r_addr, w_addr_d;
  logic [DATAWIDTH_BUS-1:0] r_data, w_data_d;
  logic [1:0]               r_errcode, w_errcode_d;
  logic                     r_mem_read, r_ir_write, r_busy, r_done, r_error;
  logic                     w_timeout;

`ifdef SC_IRFETCH_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic w_tmr_expired;

  // Loaded on REQ entry so the count reaches zero in the last allowed REQ cycle.
  sc_ir_fetch_timer #(.WIDTH(TW)) u_timer (
    .i_clk      (SC_IrFetch_CLOCK_50),
    .i_rst_n    (SC_IrFetch_Reset_InLow),
    .i_load     ((w_state_d == REQ) && (r_state != REQ)),
    .i_en       (r_state == REQ),
    .i_load_val (TW'(TIMEOUT_CYCLES - 1)),
    .o_expired  (w_tmr_expired)
  );

  assign w_timeout = (r_state == REQ) && w_tmr_expired;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_data_d    = r_data;
    w_errcode_d = r_errcode;
    case (r_state)
      IDLE, DONE: begin
        w_state_d = IDLE;
        if (bus.SC_IrFetch_Start_InHigh) begin
          w_addr_d = bus.SC_IrFetch_PC_In;
          if (word_aligned(bus.SC_IrFetch_PC_In[1:0])) begin
            w_state_d   = REQ;
            w_errcode_d = ERR_NONE;
          end else begin
            w_state_d   = ERR;
            w_errcode_d = ERR_MISALIGN;
          end
        end
      end
      REQ: begin
        // Ready in the final allowed cycle takes priority over the timeout.
        if (bus.SC_IrFetch_MemReady_InHigh) begin
          w_data_d  = bus.SC_IrFetch_MemData_In;
          w_state_d = LOAD;
        end else if (w_timeout) begin
          w_state_d   = ERR;
          w_errcode_d = ERR_TIMEOUT;
        end
      end
      LOAD:    w_state_d = DONE;
      ERR:     w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge SC_IrFetch_CLOCK_50 or negedge SC_IrFetch_Reset_InLow) begin
    if (!SC_IrFetch_Reset_InLow) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_errcode  <= ERR_NONE;
      r_mem_read <= 1'b0;
      r_ir_write <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_data     <= w_data_d;
      r_errcode  <= w_errcode_d;
      r_mem_read <= (w_state_d == REQ);
      r_ir_write <= (w_state_d == LOAD);
      r_busy     <= (w_state_d != IDLE);
      r_done     <= (w_state_d == DONE);
      r_error    <= (w_state_d == ERR);
    end
  end

  assign bus.SC_IrFetch_MemAddr_Out     = r_addr;
  assign bus.SC_IrFetch_MemRead_OutHigh = r_mem_read;
  assign bus.SC_IrFetch_DataBUS_Out     = r_data;
  assign bus.SC_IrFetch_IRWrite_OutHigh = r_ir_write;
  assign bus.SC_IrFetch_Busy_OutHigh    = r_busy;
  assign bus.SC_IrFetch_Done_OutHigh    = r_done;
  assign bus.SC_IrFetch_Error_OutHigh   = r_error;
  assign bus.SC_IrFetch_ErrCode_Out     = r_errcode;
endmodule

// File: tb/tb_sc_ir_fetch.sv
// Self-checking bench for sc_ir_fetch: per-cycle expectations derived from fetch timing rules.
module tb_sc_ir_fetch;
  import sc_ir_fetch_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   irw_seen;
  logic [DW-1:0] exp_bus;
  logic [1:0]    exp_err;

  sc_ir_fetch_if #(.DATAWIDTH_BUS(DW), .ADDRWIDTH_BUS(AW)) bus ();

  sc_ir_fetch #(.DATAWIDTH_BUS(DW), .ADDRWIDTH_BUS(AW), .TIMEOUT_CYCLES(TO)) dut (
    .SC_IrFetch_CLOCK_50    (clk),
    .SC_IrFetch_Reset_InLow (rst_n),
    .bus                    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl_obs();
    return {bus.SC_IrFetch_MemRead_OutHigh, bus.SC_IrFetch_IRWrite_OutHigh,
            bus.SC_IrFetch_Busy_OutHigh, bus.SC_IrFetch_Done_OutHigh,
            bus.SC_IrFetch_Error_OutHigh, bus.SC_IrFetch_ErrCode_Out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_aligned();
    logic [AW-1:0] a;
    a = AW'($urandom);
    return a & ~AW'(3);
  endfunction

  // Start for one cycle at pc; memory answers with data after w wait cycles.
  // Cycle k after the accepting edge: REQ for k<=w+1, LOAD at w+2, DONE at w+3.
  task automatic test_fetch(input logic [AW-1:0] pc, input logic [DW-1:0] data,
                            input int w, input bit poke);
    logic [6:0] exp;
    irw_seen = 0;
    bus.SC_IrFetch_PC_In        = pc;
    bus.SC_IrFetch_Start_InHigh = 1'b1;
    tick();
    bus.SC_IrFetch_Start_InHigh = 1'b0;
    bus.SC_IrFetch_PC_In        = AW'($urandom);
    exp_err = ERR_NONE;
    for (int k = 1; k <= w + 4; k++) begin
      if (k == w + 2) exp_bus = data;
      exp = {k <= w + 1, k == w + 2, k <= w + 3, k == w + 3, 1'b0, exp_err};
      checks++;
      if (ctrl_obs() !== exp) begin
        errors++;
        $display("FAIL fetch_ctrl pc=%h k=%0d got=%b exp=%b", pc, k, ctrl_obs(), exp);
      end
      checks++;
      if (bus.SC_IrFetch_MemAddr_Out !== pc) begin
        errors++;
        $display("FAIL fetch_addr k=%0d got=%h exp=%h", k, bus.SC_IrFetch_MemAddr_Out, pc);
      end
      checks++;
      if (bus.SC_IrFetch_DataBUS_Out !== exp_bus) begin
        errors++;
        $display("FAIL fetch_bus k=%0d got=%h exp=%h", k, bus.SC_IrFetch_DataBUS_Out, exp_bus);
      end
      if (bus.SC_IrFetch_IRWrite_OutHigh === 1'b1) irw_seen++;
      bus.SC_IrFetch_MemReady_InHigh = (k == w + 1);
      bus.SC_IrFetch_MemData_In      = (k == w + 1) ? data : DW'($urandom);
      // Misaligned Start during REQ would raise an error if it were wrongly accepted.
      bus.SC_IrFetch_Start_InHigh = poke && (k == 2) && (w >= 1);
      bus.SC_IrFetch_PC_In        = pc ^ AW'(32'h0000_0101);
      tick();
    end
    bus.SC_IrFetch_MemReady_InHigh = 1'b0;
    bus.SC_IrFetch_Start_InHigh    = 1'b0;
    checks++;
    if (irw_seen != 1) begin
      errors++;
      $display("FAIL irwrite_count got=%0d exp=1", irw_seen);
    end
  endtask

  task automatic test_reset();
    bus.SC_IrFetch_Start_InHigh    = 1'b0;
    bus.SC_IrFetch_PC_In           = '0;
    bus.SC_IrFetch_MemReady_InHigh = 1'b0;
    bus.SC_IrFetch_MemData_In      = '0;
    tick();
    tick();
    checks++;
    if (ctrl_obs() !== 7'b0 || bus.SC_IrFetch_MemAddr_Out !== '0
        || bus.SC_IrFetch_DataBUS_Out !== '0) begin
      errors++;
      $display("FAIL reset_state ctrl=%b addr=%h bus=%h exp all zero", ctrl_obs(),
               bus.SC_IrFetch_MemAddr_Out, bus.SC_IrFetch_DataBUS_Out);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    exp_bus = '0;
    exp_err = ERR_NONE;
    tick();
  endtask

  task automatic test_basic();
    test_fetch(32'h0000_0040, 32'h8A00_4002, 0, 1'b0);
    checks++;
    if (bus.SC_IrFetch_DataBUS_Out[29:25] !== 5'd5) begin
      errors++;
      $display("FAIL ir_rd_field got=%0d exp=5", bus.SC_IrFetch_DataBUS_Out[29:25]);
    end
  endtask

  task automatic test_wait_states();
    test_fetch(rand_aligned(), DW'($urandom), 5, 1'b1);
  endtask

  task automatic test_misaligned();
    logic [AW-1:0] pc;
    logic [6:0]    exp;
    for (int i = 0; i < 3; i++) begin
      pc = (i == 0) ? AW'(32'h0000_0042) : (rand_aligned() | AW'($urandom_range(1, 3)));
      bus.SC_IrFetch_PC_In        = pc;
      bus.SC_IrFetch_Start_InHigh = 1'b1;
      tick();
      bus.SC_IrFetch_Start_InHigh    = 1'b0;
      bus.SC_IrFetch_MemReady_InHigh = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        exp = {1'b0, 1'b0, k == 1, 1'b0, k == 1, ERR_MISALIGN};
        checks++;
        if (ctrl_obs() !== exp || bus.SC_IrFetch_MemAddr_Out !== pc
            || bus.SC_IrFetch_DataBUS_Out !== exp_bus) begin
          errors++;
          $display("FAIL misalign pc=%h k=%0d ctrl=%b exp=%b addr=%h bus=%h", pc, k,
                   ctrl_obs(), exp, bus.SC_IrFetch_MemAddr_Out, bus.SC_IrFetch_DataBUS_Out);
        end
        tick();
      end
      bus.SC_IrFetch_MemReady_InHigh = 1'b0;
    end
    test_fetch(rand_aligned(), DW'($urandom), int'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic test_timeout();
`ifdef SC_IRFETCH_TIMEOUT_EN
    logic [6:0]    exp;
    logic [AW-1:0] pc;
    pc = rand_aligned();
    bus.SC_IrFetch_PC_In        = pc;
    bus.SC_IrFetch_Start_InHigh = 1'b1;
    tick();
    bus.SC_IrFetch_Start_InHigh = 1'b0;
    for (int k = 1; k <= TO + 3; k++) begin
      exp = {k <= TO, 1'b0, k <= TO + 1, 1'b0, k == TO + 1,
             (k <= TO) ? ERR_NONE : ERR_TIMEOUT};
      checks++;
      if (ctrl_obs() !== exp || bus.SC_IrFetch_DataBUS_Out !== exp_bus) begin
        errors++;
        $display("FAIL timeout k=%0d ctrl=%b exp=%b bus=%h", k, ctrl_obs(), exp,
                 bus.SC_IrFetch_DataBUS_Out);
      end
      tick();
    end
    test_fetch(rand_aligned(), DW'($urandom), TO - 1, 1'b0);
`else
    test_fetch(rand_aligned(), DW'($urandom), 40, 1'b1);
`endif
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 2; p++) begin
      bus.SC_IrFetch_PC_In        = rand_aligned();
      bus.SC_IrFetch_Start_InHigh = 1'b1;
      tick();
      bus.SC_IrFetch_Start_InHigh    = 1'b0;
      bus.SC_IrFetch_MemReady_InHigh = (p == 1);
      bus.SC_IrFetch_MemData_In      = DW'($urandom);
      tick();
      bus.SC_IrFetch_MemReady_InHigh = 1'b0;
      checks++;
      if (bus.SC_IrFetch_IRWrite_OutHigh !== (p == 1)) begin
        errors++;
        $display("FAIL pre_reset_phase p=%0d irwrite=%b", p, bus.SC_IrFetch_IRWrite_OutHigh);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ctrl_obs() !== 7'b0 || bus.SC_IrFetch_MemAddr_Out !== '0
          || bus.SC_IrFetch_DataBUS_Out !== '0) begin
        errors++;
        $display("FAIL async_reset p=%0d ctrl=%b addr=%h bus=%h exp zero", p, ctrl_obs(),
                 bus.SC_IrFetch_MemAddr_Out, bus.SC_IrFetch_DataBUS_Out);
      end
      bus.SC_IrFetch_MemReady_InHigh = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if (ctrl_obs() !== 7'b0 || bus.SC_IrFetch_DataBUS_Out !== '0) begin
          errors++;
          $display("FAIL post_reset p=%0d k=%0d ctrl=%b bus=%h exp zero", p, k, ctrl_obs(),
                   bus.SC_IrFetch_DataBUS_Out);
        end
      end
      bus.SC_IrFetch_MemReady_InHigh = 1'b0;
    end
    exp_bus = '0;
    exp_err = ERR_NONE;
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [AW-1:0] pcs [N];
    logic [DW-1:0] dat [N];
    for (int i = 0; i < N; i++) begin
      pcs[i] = (i < 2) ? AW'(4 * i) : rand_aligned();
      dat[i] = DW'($urandom);
    end
    bus.SC_IrFetch_PC_In        = pcs[0];
    bus.SC_IrFetch_Start_InHigh = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ctrl_obs() !== {5'b10100, ERR_NONE} || bus.SC_IrFetch_MemAddr_Out !== pcs[i]) begin
        errors++;
        $display("FAIL b2b_req i=%0d ctrl=%b addr=%h exp_addr=%h", i, ctrl_obs(),
                 bus.SC_IrFetch_MemAddr_Out, pcs[i]);
      end
      bus.SC_IrFetch_MemReady_InHigh = 1'b1;
      bus.SC_IrFetch_MemData_In      = dat[i];
      tick();
      checks++;
      if (ctrl_obs() !== {5'b01100, ERR_NONE} || bus.SC_IrFetch_DataBUS_Out !== dat[i]) begin
        errors++;
        $display("FAIL b2b_load i=%0d ctrl=%b bus=%h exp=%h", i, ctrl_obs(),
                 bus.SC_IrFetch_DataBUS_Out, dat[i]);
      end
      bus.SC_IrFetch_MemReady_InHigh = 1'b0;
      bus.SC_IrFetch_MemData_In      = DW'($urandom);
      if (i < N - 1) bus.SC_IrFetch_PC_In = pcs[i + 1];
      else bus.SC_IrFetch_Start_InHigh = 1'b0;
      tick();
      checks++;
      if (ctrl_obs() !== {5'b00110, ERR_NONE} || bus.SC_IrFetch_MemAddr_Out !== pcs[i]) begin
        errors++;
        $display("FAIL b2b_done i=%0d ctrl=%b addr=%h exp_addr=%h", i, ctrl_obs(),
                 bus.SC_IrFetch_MemAddr_Out, pcs[i]);
      end
      tick();
    end
    checks++;
    if (ctrl_obs() !== {5'b00000, ERR_NONE}) begin
      errors++;
      $display("FAIL b2b_idle ctrl=%b", ctrl_obs());
    end
    exp_bus = dat[N - 1];
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_fetch(rand_aligned(), DW'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
